pair_stream_gen: RTL



---
 rtl/pair_pkg.sv | 17 +
 rtl/pair_stream_gen.sv | 114 +++++++++++
 2 files changed

// File: rtl/pair_pkg.sv
// Shared definitions for the pair-marked serial link.
// Used by both pair_stream_gen and pair_detect.
package pair_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MARK1 = 3'd1,
      MARK2 = 3'd2,
      DATA  = 3'd3,
      STUFF = 3'd4,
      GAP   = 3'd5
   } state_e;

   localparam logic [1:0] PAIR_MARKER = 2'b11;
   localparam logic       STUFF_BIT   = 1'b0;

endpackage

// File: rtl/pair_stream_gen.sv
// Serial transmitter: "11" marker, MSB-first data with a 0 stuffed
// after every data 1, then GAP_BITS idle zeros.
module pair_stream_gen
   import pair_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int GAP_BITS = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             outbits,
   output logic             busy,
   output logic             frame_done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int GW = $clog2(GAP_BITS + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(WIDTH);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic             out_q, out_d;
   logic             gap_end;
   logic             accept;

   // The last gap cycle also accepts, so back-to-back frames are
   // separated by exactly GAP_BITS zeros.
   assign gap_end    = (state_q == GAP) && (gap_q == GAP_LAST);
   assign in_ready   = (state_q == IDLE) || gap_end;
   assign accept     = in_valid && in_ready;
   assign busy       = (state_q != IDLE);
   assign frame_done = gap_end;
   assign outbits    = out_q;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      if (accept) begin
         state_d = MARK1;
         shift_d = in_data;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE:  state_d = IDLE;
            MARK1: state_d = MARK2;
            MARK2: state_d = DATA;
            DATA: begin
               shift_d = shift_q << 1;
               cnt_d   = cnt_q + CW'(1);
               if (shift_q[WIDTH-1]) begin
                  state_d = STUFF;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = GAP;
                  gap_d   = '0;
               end else begin
                  state_d = DATA;
               end
            end
            STUFF: begin
               if (cnt_q == CNT_END) begin
                  state_d = GAP;
                  gap_d   = '0;
               end else begin
                  state_d = DATA;
               end
            end
            GAP: begin
               if (gap_end) state_d = IDLE;
               else         gap_d   = gap_q + GW'(1);
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Line bit is registered from the state being entered.
   always_comb begin
      out_d = 1'b0;
      unique case (state_d)
         MARK1:   out_d = PAIR_MARKER[1];
         MARK2:   out_d = PAIR_MARKER[0];
         DATA:    out_d = shift_d[WIDTH-1];
         STUFF:   out_d = STUFF_BIT;
         default: out_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         out_q   <= out_d;
      end
   end

endmodule
